cq_core_arbiter: RTL and testbench
==================================

Name: cq_core_arbiter

Overview:
- Per-tile scheduler that shares one commit-queue (CQ) slice's start_task and finish_task channels among N_CORES cores.
- Two independent round-robin arbiters, each feeding a one-entry registered output stage.
- Tracks which CQ slot each core is running, and routes the CQ's broadcast abort_running_task to the owning core(s) only.
- Sits between the per-core task controllers and the CQ slice.

Parameters:
- N_CORES, 4, number of cores sharing the CQ ports (2..16).
- TILE_ID, 0, tile index; used only in debug display.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- core_start_valid  in  N_CORES  per-core start_task_valid
- core_start_ready  out  N_CORES  per-core start_task_ready
- core_start_slot  in  N_CORES*$bits(cq_slice_slot_t)  per-core start slot
- core_finish_valid  in  N_CORES  per-core finish_task_valid
- core_finish_ready  out  N_CORES  per-core finish_task_ready
- core_finish_slot  in  N_CORES*$bits(cq_slice_slot_t)  per-core finish slot
- core_finish_num_children  in  N_CORES*$bits(child_id_t)  children enqueued
- core_finish_undo_log_write  in  N_CORES  task made an undoable write
- core_abort  out  N_CORES  per-core abort_running_task pulse
- core_abort_slot  out  $bits(cq_slice_slot_t)  slot being aborted, common to all cores
- cq_start_valid  out  1  to CQ
- cq_start_ready  in  1  from CQ
- cq_start_slot  out  cq_slice_slot_t
- cq_finish_valid  out  1  to CQ
- cq_finish_ready  in  1  from CQ
- cq_finish_slot  out  cq_slice_slot_t
- cq_finish_num_children  out  child_id_t
- cq_finish_undo_log_write  out  1
- cq_finish_core  out  $clog2(N_CORES)  index of the granted core
- cq_abort_valid  in  1  CQ abort request
- cq_abort_slot  in  cq_slice_slot_t  slot to abort
- unmatched_aborts  out  32  count of aborts that matched no running core

Behaviour:
- Reset (rstn=0 at a clock edge): all valid and ready outputs 0; core_abort 0; rr pointers 0; running[] 0; unmatched_aborts 0; data outputs don't-care.
- Output stage, per channel: one entry. "Free" = !out_valid | (out_valid & cq_ready).
- When free and any core is requesting, pick one core with rr_pick, starting at ptr+1 mod N_CORES. That core's ready is asserted combinationally in the same cycle; all other readies stay 0.
- On the next edge: out_valid<=1, payload latched, ptr<=granted index.
- When not free, all readies stay 0 and the payload holds stable until the CQ accepts it.
- Latency from core handshake to cq_*_valid: 1 cycle. Back-to-back throughput: 1 per cycle while cq_ready stays high.
- Ready depends on valid and cq_ready only; it never depends on itself.
- Channels are independent. A core may be granted start and finish in the same cycle.
- running[i], slot_reg[i]:
  - Start handshake from core i sets running[i]=1 and slot_reg[i]=slot.
  - Finish handshake from core i clears running[i].
  - If both occur in the same cycle, start wins.
- Abort routing: when cq_abort_valid=1, match[i] = running[i] & slot_reg[i]==cq_abort_slot.
  - The match also includes a start handshake from core i in that same cycle with the same slot (bypass).
  - Next cycle: core_abort<=match for one cycle, and core_abort_slot<=cq_abort_slot.
  - If no core matches, unmatched_aborts increments, saturating at 32'hffff_ffff.
  - A finish handshake in the same cycle as a matching abort still delivers the abort pulse; the core ignores it after it has finished.
  - Aborts on consecutive cycles are each delivered; there is no loss.
- Reset in mid-operation: an entry pending in an output stage is dropped, and running[] is cleared.
- Round-robin wrap: ptr=N_CORES-1 wraps the search start to index 0.

Optional Feature:
- ARB_STATS_EN defined: adds 32-bit saturating outputs stat_start_stall and stat_finish_stall. Each counts cycles where out_valid & !cq_ready on its channel. Both reset to 0.
- Undefined: these ports and their counters are absent.

Decomposition:
- cq_slice_slot_t and child_id_t come from the swarm package.
- Add to swarm:
  - N_CORES_PER_TILE constant as the parameter default.
  - Typedef cq_finish_req_t packing slot, num_children, undo_log_write and core index.
- Sub-module rr_pick (parameter N): combinational one-hot/index pick from req[N] and ptr. Instantiated once per channel.

Test Plan:
- Single request: core 2 start slot 5, cq_start_ready=1 → core_start_ready[2] same cycle; cq_start_valid with slot 5 next cycle; running[2]=1.
- Fairness: all 4 cores hold finish_valid, cq_finish_ready=1 → grant order 1,2,3,0,1… (ptr starts 0), one grant per cycle.
- Backpressure: cq_start_ready=0 for 5 cycles with out_valid=1 → payload stable, all core_start_ready=0, stat_start_stall=5 (ARB_STATS_EN).
- Abort match: cores 0 and 1 running slots 3 and 7, abort slot 7 → core_abort=4'b0010 for one cycle, core_abort_slot=7.
- Abort bypass and miss:
  - Core 3 starts slot 9 in the same cycle as an abort of slot 9 → core_abort[3] pulses.
  - Abort of slot 12 with no match → unmatched_aborts=1.
- Reset mid-transfer: rstn=0 while out_valid=1 → next cycle cq_*_valid=0, running=0, counters=0.

Source files
------------

// File: rtl/cq_core_arbiter_pkg.sv
// Shared swarm types for the CQ core arbiter: slot/child widths, finish request packing,
// and small helpers used by the round-robin pick and saturating counters.
package cq_core_arbiter_pkg;

    localparam int unsigned N_CORES_PER_TILE = 4;
    localparam int unsigned CQ_SLOT_W        = 6;
    localparam int unsigned CHILD_ID_W       = 3;
    localparam int unsigned CORE_ID_W        = 4;

    typedef logic [CQ_SLOT_W-1:0]  cq_slice_slot_t;
    typedef logic [CHILD_ID_W-1:0] child_id_t;
    typedef logic [CORE_ID_W-1:0]  core_id_t;

    typedef struct packed {
        cq_slice_slot_t slot;
        child_id_t      num_children;
        logic           undo_log_write;
        core_id_t       core;
    } cq_finish_req_t;

    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned k,
                                            input int unsigned n);
        return (ptr + k) % n;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/cq_core_arbiter_if.sv
// CQ-slice side of the core arbiter: start/finish handshakes and the abort broadcast.
interface cq_core_arbiter_if
    import cq_core_arbiter_pkg::*;
#(
    parameter int unsigned N_CORES = N_CORES_PER_TILE
);
    logic                       cq_start_valid;
    logic                       cq_start_ready;
    cq_slice_slot_t             cq_start_slot;
    logic                       cq_finish_valid;
    logic                       cq_finish_ready;
    cq_slice_slot_t             cq_finish_slot;
    child_id_t                  cq_finish_num_children;
    logic                       cq_finish_undo_log_write;
    logic [$clog2(N_CORES)-1:0] cq_finish_core;
    logic                       cq_abort_valid;
    cq_slice_slot_t             cq_abort_slot;

    modport master (
        output cq_start_valid, cq_start_slot,
        output cq_finish_valid, cq_finish_slot, cq_finish_num_children,
        output cq_finish_undo_log_write, cq_finish_core,
        input  cq_start_ready, cq_finish_ready, cq_abort_valid, cq_abort_slot
    );

    modport slave (
        input  cq_start_valid, cq_start_slot,
        input  cq_finish_valid, cq_finish_slot, cq_finish_num_children,
        input  cq_finish_undo_log_write, cq_finish_core,
        output cq_start_ready, cq_finish_ready, cq_abort_valid, cq_abort_slot
    );
endinterface

// File: rtl/cq_core_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr+1 (mod N), one-hot and index.
module rr_pick
    import cq_core_arbiter_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);
    always_comb begin
        int unsigned j;
        logic [IW-1:0] jj;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        jj  = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            j  = rr_next(32'(ptr), k, N);
            jj = IW'(j);
            if (!any && req[jj]) begin
                gnt[jj] = 1'b1;
                idx     = jj;
                any     = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cq_core_arbiter.sv
// Per-tile arbiter sharing one CQ slice's start/finish channels among N_CORES cores and
// routing aborts to the owning core. Define ARB_STATS_EN to add stall-cycle counters.
module cq_core_arbiter
    import cq_core_arbiter_pkg::*;
#(
    parameter int unsigned N_CORES = N_CORES_PER_TILE,
    parameter int          TILE_ID = 0
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic [N_CORES-1:0]                    core_start_valid,
    output logic [N_CORES-1:0]                    core_start_ready,
    input  logic [N_CORES*$bits(cq_slice_slot_t)-1:0] core_start_slot,
    input  logic [N_CORES-1:0]                    core_finish_valid,
    output logic [N_CORES-1:0]                    core_finish_ready,
    input  logic [N_CORES*$bits(cq_slice_slot_t)-1:0] core_finish_slot,
    input  logic [N_CORES*$bits(child_id_t)-1:0]  core_finish_num_children,
    input  logic [N_CORES-1:0]                    core_finish_undo_log_write,
    output logic [N_CORES-1:0]                    core_abort,
    output cq_slice_slot_t                        core_abort_slot,
    cq_core_arbiter_if.master                     cq,
    output logic [31:0]                           unmatched_aborts
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]                           stat_start_stall,
    output logic [31:0]                           stat_finish_stall
`endif
);
    localparam int unsigned SW = $bits(cq_slice_slot_t);
    localparam int unsigned NW = $bits(child_id_t);
    localparam int unsigned CW = $clog2(N_CORES);

    if (N_CORES < 2 || N_CORES > 16 || TILE_ID < 0) begin : g_bad_cfg
        $error("cq_core_arbiter: unsupported N_CORES/TILE_ID");
    end

    cq_slice_slot_t       st_slot_a [N_CORES];
    cq_slice_slot_t       fn_slot_a [N_CORES];
    child_id_t            fn_nc_a   [N_CORES];
    cq_slice_slot_t       slot_reg  [N_CORES];
    logic [N_CORES-1:0]   running;
    logic [N_CORES-1:0]   abort_match;

    logic [CW-1:0]        st_ptr, fn_ptr, st_idx, fn_idx;
    logic [N_CORES-1:0]   st_gnt, fn_gnt, st_hs, fn_hs;
    logic                 st_any, fn_any, st_free, fn_free;
    logic                 st_vld_q, fn_vld_q;
    cq_slice_slot_t       st_slot_q;
    cq_finish_req_t       fn_sel, fn_q;
    logic                 core_hi_unused;

    for (genvar g = 0; g < N_CORES; g++) begin : g_core
        assign st_slot_a[g] = core_start_slot[g*SW +: SW];
        assign fn_slot_a[g] = core_finish_slot[g*SW +: SW];
        assign fn_nc_a[g]   = core_finish_num_children[g*NW +: NW];
        // A start handshake this cycle counts as running, so an abort racing it is not lost.
        assign abort_match[g] = cq.cq_abort_valid &&
            ((running[g] && slot_reg[g] == cq.cq_abort_slot) ||
             (st_hs[g] && st_slot_a[g] == cq.cq_abort_slot));
    end

    rr_pick #(.N(N_CORES)) u_start_pick (
        .req (core_start_valid),
        .ptr (st_ptr),
        .gnt (st_gnt),
        .idx (st_idx),
        .any (st_any)
    );

    rr_pick #(.N(N_CORES)) u_finish_pick (
        .req (core_finish_valid),
        .ptr (fn_ptr),
        .gnt (fn_gnt),
        .idx (fn_idx),
        .any (fn_any)
    );

    assign st_free = !st_vld_q || cq.cq_start_ready;
    assign fn_free = !fn_vld_q || cq.cq_finish_ready;
    assign st_hs   = st_free ? st_gnt : '0;
    assign fn_hs   = fn_free ? fn_gnt : '0;

    assign core_start_ready  = st_hs;
    assign core_finish_ready = fn_hs;

    always_comb begin
        fn_sel                = '0;
        fn_sel.slot           = fn_slot_a[fn_idx];
        fn_sel.num_children   = fn_nc_a[fn_idx];
        fn_sel.undo_log_write = core_finish_undo_log_write[fn_idx];
        fn_sel.core           = core_id_t'(fn_idx);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            st_vld_q <= 1'b0;
            st_ptr   <= '0;
        end else if (st_free) begin
            st_vld_q <= st_any;
            if (st_any) begin
                st_slot_q <= st_slot_a[st_idx];
                st_ptr    <= st_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            fn_vld_q <= 1'b0;
            fn_ptr   <= '0;
        end else if (fn_free) begin
            fn_vld_q <= fn_any;
            if (fn_any) begin
                fn_q   <= fn_sel;
                fn_ptr <= fn_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            running <= '0;
        end else begin
            for (int unsigned i = 0; i < N_CORES; i++) begin
                if (st_hs[i]) begin
                    running[i]  <= 1'b1;
                    slot_reg[i] <= st_slot_a[i];
                end else if (fn_hs[i]) begin
                    running[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            core_abort       <= '0;
            unmatched_aborts <= '0;
        end else begin
            core_abort <= abort_match;
            if (cq.cq_abort_valid) begin
                core_abort_slot <= cq.cq_abort_slot;
                if (abort_match == '0) begin
                    unmatched_aborts <= sat_inc(unmatched_aborts);
                end
            end
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stat_start_stall  <= '0;
            stat_finish_stall <= '0;
        end else begin
            if (st_vld_q && !cq.cq_start_ready) stat_start_stall <= sat_inc(stat_start_stall);
            if (fn_vld_q && !cq.cq_finish_ready) stat_finish_stall <= sat_inc(stat_finish_stall);
        end
    end
`endif

    assign cq.cq_start_valid           = st_vld_q;
    assign cq.cq_start_slot            = st_slot_q;
    assign cq.cq_finish_valid          = fn_vld_q;
    assign cq.cq_finish_slot           = fn_q.slot;
    assign cq.cq_finish_num_children   = fn_q.num_children;
    assign cq.cq_finish_undo_log_write = fn_q.undo_log_write;
    assign cq.cq_finish_core           = fn_q.core[CW-1:0];
    // Core id field is sized for the largest tile; only the low CW bits leave the block.
    assign core_hi_unused              = ^fn_q.core;

endmodule

// File: tb/tb_cq_core_arbiter.sv
// Directed-vector bench for cq_core_arbiter with N_CORES=4; stall counters checked when ARB_STATS_EN is defined.
module tb_cq_core_arbiter;
    import cq_core_arbiter_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned SW = $bits(cq_slice_slot_t);
    localparam int unsigned NW = $bits(child_id_t);

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [N-1:0]         core_start_valid;
    logic [N-1:0]         core_start_ready;
    logic [N*SW-1:0]      core_start_slot;
    logic [N-1:0]         core_finish_valid;
    logic [N-1:0]         core_finish_ready;
    logic [N*SW-1:0]      core_finish_slot;
    logic [N*NW-1:0]      core_finish_num_children;
    logic [N-1:0]         core_finish_undo_log_write;
    logic [N-1:0]         core_abort;
    cq_slice_slot_t       core_abort_slot;
    logic [31:0]          unmatched_aborts;
`ifdef ARB_STATS_EN
    logic [31:0]          stat_start_stall;
    logic [31:0]          stat_finish_stall;
`endif

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    cq_core_arbiter_if #(.N_CORES(N)) cq_if ();

    cq_core_arbiter #(.N_CORES(N), .TILE_ID(0)) dut (
        .clk                        (clk),
        .rstn                       (rstn),
        .core_start_valid           (core_start_valid),
        .core_start_ready           (core_start_ready),
        .core_start_slot            (core_start_slot),
        .core_finish_valid          (core_finish_valid),
        .core_finish_ready          (core_finish_ready),
        .core_finish_slot           (core_finish_slot),
        .core_finish_num_children   (core_finish_num_children),
        .core_finish_undo_log_write (core_finish_undo_log_write),
        .core_abort                 (core_abort),
        .core_abort_slot            (core_abort_slot),
        .cq                         (cq_if),
        .unmatched_aborts           (unmatched_aborts)
`ifdef ARB_STATS_EN
        ,
        .stat_start_stall           (stat_start_stall),
        .stat_finish_stall          (stat_finish_stall)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_start(input int c, input logic v, input int s);
        core_start_valid[c]          = v;
        core_start_slot[c*SW +: SW]  = SW'(s);
    endtask

    task automatic set_finish(input int c, input logic v, input int s, input int nc, input logic u);
        core_finish_valid[c]                 = v;
        core_finish_slot[c*SW +: SW]         = SW'(s);
        core_finish_num_children[c*NW +: NW] = NW'(nc);
        core_finish_undo_log_write[c]        = u;
    endtask

    task automatic abort(input logic v, input int s);
        cq_if.cq_abort_valid = v;
        cq_if.cq_abort_slot  = SW'(s);
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int g;
        rstn                       = 1'b0;
        core_start_valid           = '0;
        core_start_slot            = '0;
        core_finish_valid          = '0;
        core_finish_slot           = '0;
        core_finish_num_children   = '0;
        core_finish_undo_log_write = '0;
        cq_if.cq_start_ready       = 1'b0;
        cq_if.cq_finish_ready      = 1'b0;
        abort(1'b0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_start_valid", 32'(cq_if.cq_start_valid), 0);
        chk("rst_finish_valid", 32'(cq_if.cq_finish_valid), 0);
        chk("rst_core_abort", 32'(core_abort), 0);
        chk("rst_unmatched", unmatched_aborts, 0);
`ifdef ARB_STATS_EN
        chk("rst_stat_start", stat_start_stall, 0);
        chk("rst_stat_finish", stat_finish_stall, 0);
`endif
        @(negedge clk);
        rstn = 1'b1;

        // single start request from core 2
        @(negedge clk);
        set_start(2, 1'b1, 5);
        cq_if.cq_start_ready = 1'b1;
        #1 chk("single_ready", 32'(core_start_ready), 32'b0100);
        post_edge();
        chk("single_cq_valid", 32'(cq_if.cq_start_valid), 1);
        chk("single_cq_slot", 32'(cq_if.cq_start_slot), 5);
        @(negedge clk);
        set_start(2, 1'b0, 0);
        abort(1'b1, 5);
        post_edge();
        chk("running2_abort", 32'(core_abort), 32'b0100);
        chk("running2_abort_slot", 32'(core_abort_slot), 5);
        chk("start_drained", 32'(cq_if.cq_start_valid), 0);
        @(negedge clk);
        abort(1'b0, 0);
        post_edge();
        chk("abort_one_cycle", 32'(core_abort), 0);

        // fairness on the finish channel, including wrap 3 -> 0
        @(negedge clk);
        for (int c = 0; c < 4; c++) set_finish(c, 1'b1, 20 + c, c + 1, c[0]);
        cq_if.cq_finish_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            g = (k + 1) % 4;
            #1 chk("rr_ready", 32'(core_finish_ready), 32'(1) << g);
            post_edge();
            chk("rr_valid", 32'(cq_if.cq_finish_valid), 1);
            chk("rr_core", 32'(cq_if.cq_finish_core), 32'(g));
            chk("rr_slot", 32'(cq_if.cq_finish_slot), 32'(20 + g));
            chk("rr_nc", 32'(cq_if.cq_finish_num_children), 32'(g + 1));
            chk("rr_undo", 32'(cq_if.cq_finish_undo_log_write), 32'(g % 2));
            @(negedge clk);
        end
        for (int c = 0; c < 4; c++) set_finish(c, 1'b0, 0, 0, 1'b0);
        post_edge();
        chk("finish_drained", 32'(cq_if.cq_finish_valid), 0);

        // backpressure on the start channel
        @(negedge clk);
        cq_if.cq_start_ready = 1'b0;
        set_start(0, 1'b1, 3);
        #1 chk("bp_first_ready", 32'(core_start_ready), 32'b0001);
        post_edge();
        chk("bp_first_valid", 32'(cq_if.cq_start_valid), 1);
        @(negedge clk);
        set_start(0, 1'b0, 0);
        set_start(1, 1'b1, 7);
        for (int k = 0; k < 5; k++) begin
            #1 chk("bp_ready_low", 32'(core_start_ready), 0);
            post_edge();
            chk("bp_valid_hold", 32'(cq_if.cq_start_valid), 1);
            chk("bp_slot_hold", 32'(cq_if.cq_start_slot), 3);
            @(negedge clk);
        end
`ifdef ARB_STATS_EN
        chk("bp_stat", stat_start_stall, 5);
`endif
        cq_if.cq_start_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(core_start_ready), 32'b0010);
        post_edge();
        chk("bp_next_slot", 32'(cq_if.cq_start_slot), 7);
`ifdef ARB_STATS_EN
        chk("bp_stat_after", stat_start_stall, 5);
`endif
        @(negedge clk);
        set_start(1, 1'b0, 0);

        // abort match and back-to-back aborts
        abort(1'b1, 7);
        post_edge();
        chk("abort7", 32'(core_abort), 32'b0010);
        chk("abort7_slot", 32'(core_abort_slot), 7);
        @(negedge clk);
        abort(1'b1, 3);
        post_edge();
        chk("abort3", 32'(core_abort), 32'b0001);
        chk("abort3_slot", 32'(core_abort_slot), 3);
        @(negedge clk);
        abort(1'b0, 0);
        post_edge();
        chk("abort_idle", 32'(core_abort), 0);
        chk("unmatched_zero", unmatched_aborts, 0);

        // bypass: start and abort of slot 9 in the same cycle
        @(negedge clk);
        set_start(3, 1'b1, 9);
        abort(1'b1, 9);
        #1 chk("bypass_ready", 32'(core_start_ready), 32'b1000);
        post_edge();
        chk("bypass_abort", 32'(core_abort), 32'b1000);
        chk("bypass_cq_slot", 32'(cq_if.cq_start_slot), 9);
        @(negedge clk);
        set_start(3, 1'b0, 0);
        abort(1'b1, 12);
        post_edge();
        chk("miss_abort", 32'(core_abort), 0);
        chk("miss_count", unmatched_aborts, 1);

        // finish and abort in the same cycle still delivers; later abort misses
        @(negedge clk);
        set_finish(3, 1'b1, 9, 0, 1'b0);
        abort(1'b1, 9);
        #1 chk("fin_abort_ready", 32'(core_finish_ready), 32'b1000);
        post_edge();
        chk("fin_abort_pulse", 32'(core_abort), 32'b1000);
        chk("fin_abort_core", 32'(cq_if.cq_finish_core), 3);
        @(negedge clk);
        set_finish(3, 1'b0, 0, 0, 1'b0);
        abort(1'b1, 9);
        post_edge();
        chk("after_finish_abort", 32'(core_abort), 0);
        chk("after_finish_count", unmatched_aborts, 2);
        @(negedge clk);
        abort(1'b0, 0);

        // reset with both stages holding entries
        cq_if.cq_start_ready  = 1'b0;
        cq_if.cq_finish_ready = 1'b0;
        set_start(1, 1'b1, 4);
        set_finish(2, 1'b1, 6, 1, 1'b0);
        post_edge();
        chk("pre_rst_start", 32'(cq_if.cq_start_valid), 1);
        chk("pre_rst_finish", 32'(cq_if.cq_finish_valid), 1);
        @(negedge clk);
        set_start(1, 1'b0, 0);
        set_finish(2, 1'b0, 0, 0, 1'b0);
        rstn = 1'b0;
        post_edge();
        chk("mid_rst_start", 32'(cq_if.cq_start_valid), 0);
        chk("mid_rst_finish", 32'(cq_if.cq_finish_valid), 0);
        chk("mid_rst_unmatched", unmatched_aborts, 0);
`ifdef ARB_STATS_EN
        chk("mid_rst_stat_start", stat_start_stall, 0);
        chk("mid_rst_stat_finish", stat_finish_stall, 0);
`endif
        @(negedge clk);
        rstn = 1'b1;
        cq_if.cq_start_ready  = 1'b1;
        cq_if.cq_finish_ready = 1'b1;
        abort(1'b1, 4);
        post_edge();
        chk("post_rst_no_running", 32'(core_abort), 0);
        chk("post_rst_unmatched", unmatched_aborts, 1);
        @(negedge clk);
        abort(1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
